// File: rtl/ofmap_collector.sv
// ofmap_collector: accumulates DEPTH column partial sums over passes, then drains them.
// Define OFMAP_COLLECTOR_SAT_EN to saturate overflowing adds instead of wrapping.
module ofmap_collector #(
   parameter int OFMAP_WIDTH = 8,
   parameter int ACC_WIDTH   = 12,
   parameter int DEPTH       = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [OFMAP_WIDTH-1:0] ofmap_in_i,
   input  logic                   pass_first_i,
   input  logic                   pass_last_i,
   input  logic                   clear_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [ACC_WIDTH-1:0]   out_data_o,
   output logic                   overflow_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef enum logic {ACCUM, DRAIN} state_e;

   state_e               state_q, state_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ACC_WIDTH-1:0] buf_q [DEPTH];
   logic [ACC_WIDTH-1:0] buf_d [DEPTH];
   logic                 ovf_q, ovf_d;
   logic [ACC_WIDTH:0]   sum;
   logic [ACC_WIDTH-1:0] wr_val;
   logic                 beat, xfer;

   assign in_ready_o  = rst_ni && state_q == ACCUM;
   assign out_valid_o = state_q == DRAIN;
   assign out_data_o  = buf_q[rd_ptr_q];
   assign overflow_o  = ovf_q;
   assign beat        = in_valid_i && in_ready_o;
   assign xfer        = out_valid_o && out_ready_i;
   // One extra bit so the carry out of the entry is visible as overflow
   assign sum = {1'b0, buf_q[wr_ptr_q]} + (ACC_WIDTH + 1)'(ofmap_in_i);

`ifdef OFMAP_COLLECTOR_SAT_EN
   assign wr_val = pass_first_i ? ACC_WIDTH'(ofmap_in_i) : sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
   assign wr_val = pass_first_i ? ACC_WIDTH'(ofmap_in_i) : sum[ACC_WIDTH-1:0];
`endif

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      buf_d    = buf_q;
      ovf_d    = ovf_q;
      if (clear_i) begin
         state_d  = ACCUM;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         buf_d    = '{default: '0};
         ovf_d    = 1'b0;
      end else if (beat) begin
         buf_d[wr_ptr_q] = wr_val;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         // A new result set starts at the first overwrite of entry 0
         ovf_d = (pass_first_i && wr_ptr_q == '0) ? 1'b0 : ovf_q | (!pass_first_i && sum[ACC_WIDTH]);
         if (wr_ptr_q == LAST && pass_last_i) state_d = DRAIN;
      end else if (xfer) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (rd_ptr_q == LAST) state_d = ACCUM;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ACCUM;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         buf_q    <= '{default: '0};
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         buf_q    <= buf_d;
         ovf_q    <= ovf_d;
      end
   end
endmodule

// File: tb/tb_ofmap_collector.sv
// tb_ofmap_collector: directed checks of ofmap_collector at OFMAP_WIDTH=8, ACC_WIDTH=12, DEPTH=4.
module tb_ofmap_collector;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, pass_first, pass_last, clear;
   logic        out_valid, out_ready, overflow;
   logic [7:0]  ofmap_in;
   logic [11:0] out_data;
   int          n_checks = 0;
   int          n_errors = 0;

   ofmap_collector #(.OFMAP_WIDTH(8), .ACC_WIDTH(12), .DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .ofmap_in_i(ofmap_in), .pass_first_i(pass_first), .pass_last_i(pass_last),
      .clear_i(clear), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic send_pass(input logic [7:0] a, b, c, d, input logic first, last);
      logic [7:0] v [4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; ofmap_in = v[i]; pass_first = first; pass_last = last;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input logic [11:0] a, b, c, d);
      logic [11:0] e [4];
      e = '{a, b, c, d};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, e[i]);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("drain_done_valid", out_valid, 0);
      chk("drain_done_ready", in_ready, 1);
   endtask

   initial begin
      logic [6:0]  pat;
      int          idx;
      logic [11:0] e3 [4];
      rst_n = 1'b0; in_valid = 1'b0; ofmap_in = '0; pass_first = 1'b0;
      pass_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      // single pass first=last
      send_pass(1, 2, 3, 4, 1, 1);
      chk("p1_in_ready", in_ready, 0);
      drain(1, 2, 3, 4);

      // three accumulating passes
      send_pass(10, 20, 30, 40, 1, 0);
      chk("p3a_valid", out_valid, 0);
      send_pass(10, 20, 30, 40, 0, 0);
      chk("p3b_valid", out_valid, 0);
      send_pass(10, 20, 30, 40, 0, 1);
      drain(30, 60, 90, 120);
      chk("p3_overflow", overflow, 0);

      // drain with stalls: transfers at steps 0,3,4,6
      send_pass(1, 2, 3, 4, 1, 1);
      e3 = '{1, 2, 3, 4};
      pat = 7'b1011001;
      idx = 0;
      for (int k = 0; k < 7; k++) begin
         out_ready = pat[k];
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_data", out_data, e3[idx]);
         @(negedge clk);
         if (pat[k]) idx++;
      end
      out_ready = 1'b0;
      chk("stall_xfers", idx, 4);
      chk("stall_end_valid", out_valid, 0);
      chk("stall_end_ready", in_ready, 1);

      // 17 passes of 255 at entry 0
      send_pass(255, 0, 0, 0, 1, 0);
      for (int p = 0; p < 15; p++) send_pass(255, 0, 0, 0, 0, 0);
      chk("ovf_before", overflow, 0);
      send_pass(255, 0, 0, 0, 0, 1);
      chk("ovf_after", overflow, 1);
`ifdef OFMAP_COLLECTOR_SAT_EN
      drain(4095, 0, 0, 0);
`else
      drain(239, 0, 0, 0);
`endif
      chk("ovf_sticky", overflow, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_ovf", overflow, 0);

      // clear during drain after two transfers
      send_pass(1, 2, 3, 4, 1, 1);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_clear_data", out_data, 3);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; out_ready = 1'b0;
      chk("clear_valid", out_valid, 0);
      chk("clear_ready", in_ready, 1);
      send_pass(5, 6, 7, 8, 1, 1);
      drain(5, 6, 7, 8);

      // reset mid-pass after two beats; next first=0 pass adds to zero
      in_valid = 1'b1; pass_first = 1'b1; pass_last = 1'b1;
      ofmap_in = 9; @(negedge clk);
      ofmap_in = 9; @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      send_pass(5, 6, 7, 8, 0, 1);
      drain(5, 6, 7, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ofmap_collector.md
OFMAP_COLLECTOR -- requirements
Module: ofmap_collector

Interface
REQ-001 Parameter OFMAP_WIDTH, default 8: width of the partial sum taken from the bottom mac of a systolic column.
REQ-002 Parameter ACC_WIDTH, default 12: accumulator entry width; SHALL be >= OFMAP_WIDTH.
REQ-003 Parameter DEPTH, default 4: ofmap entries per pass; SHALL be a power of two >= 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  ofmap_in carries a partial sum this cycle.
REQ-007 in_ready  output  1  collector accepts a beat this cycle.
REQ-008 ofmap_in  input  OFMAP_WIDTH  unsigned partial sum, driven from the column's bottom mac ofmap_out.
REQ-009 pass_first  input  1  current pass overwrites entries; held stable for the whole pass.
REQ-010 pass_last  input  1  current pass is the final pass; held stable for the whole pass.
REQ-011 clear  input  1  synchronous abort; discards all contents.
REQ-012 out_valid  output  1  out_data holds a finished entry.
REQ-013 out_ready  input  1  downstream consumes out_data.
REQ-014 out_data  output  ACC_WIDTH  finished accumulated entry.
REQ-015 overflow  output  1  sticky flag: an accumulation exceeded ACC_WIDTH in the current result set.

Function
REQ-016 Two states: ACCUM and DRAIN; reset state SHALL be ACCUM.
REQ-017 ACCUM: in_ready=1, out_valid=0; a beat is accepted when in_valid && in_ready.
REQ-018 On an accepted beat: buf[wr_ptr] <= pass_first ? zero-extended ofmap_in : buf[wr_ptr] + ofmap_in. wr_ptr increments.
REQ-019 wr_ptr SHALL wrap from DEPTH-1 to 0. The beat written at DEPTH-1 ends the pass.
REQ-020 When a pass ends with pass_last=1, the state SHALL move to DRAIN on the next cycle. Otherwise it SHALL stay in ACCUM for the next pass.
REQ-021 DRAIN: in_ready=0, out_valid=1, out_data=buf[rd_ptr]; ofmap_in is ignored.
REQ-022 In DRAIN, on out_valid && out_ready, rd_ptr increments.
REQ-023 After the transfer at rd_ptr=DEPTH-1, rd_ptr SHALL wrap to 0 and the state SHALL return to ACCUM.
REQ-024 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 A transfer moves one entry per cycle; back-to-back transfers SHALL be supported.
REQ-026 overflow SHALL set on any add whose true sum exceeds 2^ACC_WIDTH-1.
REQ-027 overflow SHALL clear on the first accepted beat with pass_first=1 at wr_ptr=0.
REQ-028 clear=1 SHALL force ACCUM, wr_ptr=0, rd_ptr=0, overflow=0 and out_valid=0 on the next cycle, in either state. clear takes priority over any simultaneous beat or transfer.
REQ-029 An accumulation beat with pass_first=0 in the very first pass after reset or clear SHALL add to zero, because buf resets to zero.

Reset
REQ-030 rst_n low SHALL immediately force: state=ACCUM, wr_ptr=0, rd_ptr=0, all buf entries=0, overflow=0, out_valid=0, out_data=0, in_ready=1 (the last while rst_n is high).
REQ-031 in_ready SHALL be 0 while rst_n=0.
REQ-032 Reset asserted mid-pass or mid-drain SHALL discard all partial results; no output beat is produced for them.

Configuration
REQ-033 Macro OFMAP_COLLECTOR_SAT_EN: when defined, an add that overflows SHALL saturate the entry to 2^ACC_WIDTH-1. When undefined, the sum SHALL wrap modulo 2^ACC_WIDTH. overflow behaves identically in both builds.

Verification (OFMAP_WIDTH=8, ACC_WIDTH=12, DEPTH=4)
REQ-034 Single pass, first=last=1, inputs 1,2,3,4 -> DRAIN outputs 1,2,3,4 with out_ready held 1; then ACCUM with in_ready=1.
REQ-035 Three passes of 10,20,30,40 each (first on pass 1, last on pass 3) -> outputs 30,60,90,120; overflow=0.
REQ-036 Drain with out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 transfers; out_data stable during stalls; in_ready=0 until the 4th transfer completes.
REQ-037 Seventeen passes of 255 at entry 0 -> with SAT_EN, entry 0=4095 and overflow=1; without it, entry 0=4335 mod 4096=239 and overflow=1.
REQ-038 clear asserted during DRAIN after 2 transfers, and rst_n pulsed mid-pass after 2 beats -> out_valid=0 next cycle; new pass of 5,6,7,8 with first=last=1 -> outputs 5,6,7,8.
